// File: rtl/sram_multibeat_ctrl_pkg.sv
// Shared types and elaboration helpers for the multi-beat SRAM controller.
package sram_ctrl_pkg;

    localparam int SRAM_DQ_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Width needed to hold 0..v-1, never less than one bit.
    function automatic int clog2_min1(input int v);
        int r;
        r = 1;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    function automatic int beats_of(input int data_w, input int dq_w);
        return data_w / dq_w;
    endfunction

    function automatic int t_beat_of(input int wait_cycles);
        return wait_cycles + 1;
    endfunction

endpackage

// File: rtl/sram_multibeat_ctrl_if.sv
// Requester-side bus between the MEM pipeline stage and the SRAM controller.
interface sram_multibeat_ctrl_if #(
    parameter int DATA_W = 32
);
    // Handshake: the requester holds rd_en/wr_en (and its operands) as a level;
    // the transfer completes in the cycle where a request is high and ready is
    // high. ready is also high in IDLE when nothing is requested, so an idle
    // pipeline never stalls. err qualifies the completing cycle only.
    logic                  wr_en;
    logic                  rd_en;
    logic [31:0]           address;
    logic [DATA_W-1:0]     writeData;
    logic [DATA_W/8-1:0]   byteEn;
    logic [DATA_W-1:0]     readData;
    logic                  ready;
    logic                  err;

    modport master (
        output wr_en, rd_en, address, writeData, byteEn,
        input  readData, ready, err
    );

    modport slave (
        input  wr_en, rd_en, address, writeData, byteEn,
        output readData, ready, err
    );

endinterface

// File: rtl/sram_multibeat_ctrl_beat_counter.sv
// Beat index and per-beat wait-cycle counter for the SRAM access sequence.
module sram_beat_counter
    import sram_ctrl_pkg::*;
#(
    parameter int BEATS  = 2,
    parameter int T_BEAT = 2,
    localparam int BW    = clog2_min1(BEATS),
    localparam int WW    = clog2_min1(T_BEAT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          en,
    output logic [BW-1:0] beat,
    output logic          last_cycle,
    output logic          last_beat
);

    logic [WW-1:0] wcnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            beat <= '0;
            wcnt <= '0;
        end else if (en) begin
            if (last_cycle) begin
                wcnt <= '0;
                beat <= beat + 1'b1;
            end else begin
                wcnt <= wcnt + 1'b1;
            end
        end
    end

    assign last_cycle = (wcnt == WW'(T_BEAT - 1));
    assign last_beat  = (beat == BW'(BEATS - 1));

endmodule

// File: rtl/sram_multibeat_ctrl.sv
// Splits one requester word into narrow SRAM beats with wait states, byte
// enables, out-of-range detection and a registered read result.
module sram_multibeat_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int          DATA_W      = 32,
    parameter int          SRAM_DQ_W   = SRAM_DQ_WIDTH,
    parameter int          SRAM_ADDR_W = 18,
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_multibeat_ctrl_if.slave   bus,
    inout  wire  [SRAM_DQ_W-1:0]   SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_OE_N,
    output state_t                 state_dbg
);

    localparam int BEATS  = beats_of(DATA_W, SRAM_DQ_W);
    localparam int T_BEAT = t_beat_of(WAIT_CYCLES);
    localparam int BW     = clog2_min1(BEATS);
    localparam int BYTES  = DATA_W / 8;

    state_t                 state, state_next;
    logic                   op_wr, oor;
    logic [SRAM_ADDR_W-1:0] word_addr;
    logic [DATA_W-1:0]      wdata, rdata;
    logic [BYTES-1:0]       be;
    logic                   req, req_oor, in_access;
    logic [31:0]            offset_hw;
    logic [BW-1:0]          beat;
    logic                   last_cycle, last_beat;
    logic                   dq_drive;
    logic [SRAM_DQ_W-1:0]   dq_out;

    assign req       = bus.rd_en | bus.wr_en;
    assign in_access = (state == ACCESS);

    // Half-word offset, aligned down to a whole requester word.
    assign offset_hw = ((bus.address - BASE_ADDR) >> 1) & ~32'(BYTES / 2 - 1);
    assign req_oor   = (bus.address < BASE_ADDR) || ((offset_hw >> SRAM_ADDR_W) != 32'd0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = req_oor ? DONE : ACCESS;
            ACCESS:  if (last_cycle && last_beat) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_wr     <= 1'b0;
            oor       <= 1'b0;
            word_addr <= '0;
            wdata     <= '0;
            be        <= '0;
        end else if (state == IDLE && req) begin
            op_wr     <= bus.wr_en;
            oor       <= req_oor;
            word_addr <= offset_hw[SRAM_ADDR_W-1:0];
            wdata     <= bus.writeData;
            be        <= bus.byteEn;
        end
    end

    // Each read slice lands on the edge that ends its beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (state == IDLE && req && req_oor) begin
            rdata <= '0;
        end else if (in_access && !op_wr && last_cycle) begin
            rdata[int'(beat)*SRAM_DQ_W +: SRAM_DQ_W] <= SRAM_DQ;
        end
    end

    sram_beat_counter #(
        .BEATS  (BEATS),
        .T_BEAT (T_BEAT)
    ) u_beat_counter (
        .clk        (clk),
        .rst        (rst),
        .clear      (!in_access),
        .en         (in_access),
        .beat       (beat),
        .last_cycle (last_cycle),
        .last_beat  (last_beat)
    );

    always_comb begin
        SRAM_ADDR = '0;
        SRAM_CE_N = 1'b1;
        SRAM_WE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        SRAM_LB_N = 1'b1;
        SRAM_UB_N = 1'b1;
        dq_drive  = 1'b0;
        dq_out    = wdata[int'(beat)*SRAM_DQ_W +: SRAM_DQ_W];
        if (in_access) begin
            SRAM_ADDR = word_addr + SRAM_ADDR_W'(beat);
            SRAM_CE_N = 1'b0;
            if (op_wr) begin
                // WE_N rises for the final cycle so data is held past the strobe.
                SRAM_WE_N = last_cycle;
                SRAM_LB_N = ~be[2*int'(beat)];
                SRAM_UB_N = ~be[2*int'(beat)+1];
                dq_drive  = 1'b1;
            end else begin
                SRAM_OE_N = 1'b0;
                SRAM_LB_N = 1'b0;
                SRAM_UB_N = 1'b0;
            end
        end
    end

    assign SRAM_DQ      = dq_drive ? dq_out : 'z;
    assign bus.ready    = (state == DONE) | ((state == IDLE) & !req);
    assign bus.err      = (state == DONE) & oor;
    assign bus.readData = rdata;
    assign state_dbg    = state;

endmodule

// File: tb/tb_sram_multibeat_ctrl.sv
// Directed bench: default-parameter controller plus a WAIT_CYCLES=3 instance,
// each attached to a behavioural asynchronous SRAM.
module tb_sram_multibeat_ctrl;
    import sram_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_multibeat_ctrl_if #(.DATA_W(32)) if0 ();
    sram_multibeat_ctrl_if #(.DATA_W(32)) if1 ();

    wire  [15:0] dq0, dq1;
    logic [17:0] a0, a1;
    logic        ce0, we0, oe0, lb0, ub0;
    logic        ce1, we1, oe1, lb1, ub1;
    state_t      st0, st1;

    sram_multibeat_ctrl u0 (
        .clk(clk), .rst(rst), .bus(if0.slave), .SRAM_DQ(dq0), .SRAM_ADDR(a0),
        .SRAM_UB_N(ub0), .SRAM_LB_N(lb0), .SRAM_WE_N(we0), .SRAM_CE_N(ce0),
        .SRAM_OE_N(oe0), .state_dbg(st0)
    );

    sram_multibeat_ctrl #(.WAIT_CYCLES(3)) u1 (
        .clk(clk), .rst(rst), .bus(if1.slave), .SRAM_DQ(dq1), .SRAM_ADDR(a1),
        .SRAM_UB_N(ub1), .SRAM_LB_N(lb1), .SRAM_WE_N(we1), .SRAM_CE_N(ce1),
        .SRAM_OE_N(oe1), .state_dbg(st1)
    );

    // Behavioural SRAMs: drive DQ on CE&OE, write enabled lanes while CE&WE low.
    logic [15:0] mem0 [0:262143];
    logic [15:0] mem1 [0:262143];

    assign dq0 = (!ce0 && !oe0) ? mem0[a0] : 16'bz;
    assign dq1 = (!ce1 && !oe1) ? mem1[a1] : 16'bz;

    always @(posedge clk) begin
        if (!ce0 && !we0) begin
            if (!lb0) mem0[a0][7:0]  <= dq0[7:0];
            if (!ub0) mem0[a0][15:8] <= dq0[15:8];
        end
        if (!ce1 && !we1) begin
            if (!lb1) mem1[a1][7:0]  <= dq1[7:0];
            if (!ub1) mem1[a1][15:8] <= dq1[15:8];
        end
    end

    typedef struct packed {
        logic        ready;
        logic        err;
        logic [31:0] rdata;
        logic [17:0] addr;
        logic [15:0] dq;
        logic        ce_n, we_n, oe_n, lb_n, ub_n;
    } obs_t;

    obs_t ob [2];
    assign ob[0] = '{if0.ready, if0.err, if0.readData, a0, dq0, ce0, we0, oe0, lb0, ub0};
    assign ob[1] = '{if1.ready, if1.err, if1.readData, a1, dq1, ce1, we1, oe1, lb1, ub1};

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          cyc;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    int checks = 0;
    int passed = 0;
    logic [31:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, got, exp, $time);
    endtask

    task automatic drive(input int sel, input logic wr, input logic rd,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        if (sel == 0) begin
            if0.wr_en = wr; if0.rd_en = rd; if0.address = addr;
            if0.writeData = wdata; if0.byteEn = be;
        end else begin
            if1.wr_en = wr; if1.rd_en = rd; if1.address = addr;
            if1.writeData = wdata; if1.byteEn = be;
        end
    endtask

    function automatic logic [15:0] mem_at(input int sel, input logic [17:0] a);
        return (sel == 0) ? mem0[a] : mem1[a];
    endfunction

    // Pin expectations for one ACCESS cycle c (1-based) with T_BEAT t.
    task automatic check_beat(input int sel, input vec_t v, input logic [17:0] base,
                              input int c, input int t);
        int k;
        int w;
        logic [17:0] ea;
        k  = (c - 1) / t;
        w  = (c - 1) % t;
        ea = base + 18'(k);
        check("beat_addr", 32'(ob[sel].addr), 32'(ea));
        check("beat_ce_n", 32'(ob[sel].ce_n), 32'd0);
        if (v.wr) begin
            check("wr_we_n", 32'(ob[sel].we_n), 32'(w == t - 1));
            check("wr_oe_n", 32'(ob[sel].oe_n), 32'd1);
            check("wr_dq",   32'(ob[sel].dq),   32'(v.wdata[16*k +: 16]));
            check("wr_lb_n", 32'(ob[sel].lb_n), 32'(!v.be[2*k]));
            check("wr_ub_n", 32'(ob[sel].ub_n), 32'(!v.be[2*k+1]));
        end else begin
            check("rd_we_n", 32'(ob[sel].we_n), 32'd1);
            check("rd_oe_n", 32'(ob[sel].oe_n), 32'd0);
            check("rd_lanes", 32'({ob[sel].ub_n, ob[sel].lb_n}), 32'd0);
            check("rd_dq_uncontended", 32'(ob[sel].dq), 32'(mem_at(sel, ea)));
        end
    endtask

    // Starts in IDLE just after a negedge; ends one cycle after DONE, back in IDLE.
    task automatic run_txn(input int sel, input vec_t v);
        int t;
        int got;
        logic [17:0] base;
        logic [31:0] exp_rd;
        t    = (sel == 0) ? 2 : 4;
        got  = -1;
        base = 18'(((v.addr - 32'd1024) & ~32'd3) >> 1);
        exp_q.push_back(v.rdata);
        drive(sel, v.wr, v.rd, v.addr, v.wdata, v.be);
        for (int c = 0; c <= 20 && got < 0; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (c == 0 || v.err) check("ce_n_idle", 32'(ob[sel].ce_n), 32'd1);
            if (c > 0 && !v.err && c < v.cyc) check_beat(sel, v, base, c, t);
            if (ob[sel].ready) got = c;
        end
        check("ready_cycle", 32'(got), 32'(v.cyc));
        exp_rd = exp_q.pop_front();
        check("done_err", 32'(ob[sel].err), 32'(v.err));
        check("read_data", ob[sel].rdata, exp_rd);
        drive(sel, 1'b0, 1'b0, v.addr, v.wdata, v.be);
        @(negedge clk);
        #1;
        check("idle_ready", 32'(ob[sel].ready), 32'd1);
        check("idle_err", 32'(ob[sel].err), 32'd0);
    endtask

    initial begin
        vec_t w;
        //            wr    rd    addr         wdata          be       cyc err   rdata
        vecs[0]  = '{1'b1, 1'b0, 32'd1024,   32'hDEADBEEF, 4'hF,    5, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 32'd1024,   32'h0,        4'h0,    5, 1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 1'b0, 32'd1032,   32'hAABBCCDD, 4'hF,    5, 1'b0, 32'hDEADBEEF};
        vecs[3]  = '{1'b1, 1'b0, 32'd1032,   32'h11223344, 4'b0101, 5, 1'b0, 32'hDEADBEEF};
        vecs[4]  = '{1'b0, 1'b1, 32'd1032,   32'h0,        4'h0,    5, 1'b0, 32'hAA22CC44};
        vecs[5]  = '{1'b0, 1'b1, 32'd1000,   32'h0,        4'h0,    1, 1'b1, 32'h0};
        vecs[6]  = '{1'b0, 1'b1, 32'd525312, 32'h0,        4'h0,    1, 1'b1, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 32'd525308, 32'h12345678, 4'hF,    5, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 1'b1, 32'd525308, 32'h0,        4'h0,    5, 1'b0, 32'h12345678};
        vecs[9]  = '{1'b1, 1'b1, 32'd1040,   32'hCAFEF00D, 4'hF,    5, 1'b0, 32'h12345678};
        vecs[10] = '{1'b0, 1'b1, 32'd1040,   32'h0,        4'h0,    5, 1'b0, 32'hCAFEF00D};
        vecs[11] = '{1'b1, 1'b0, 32'd1000,   32'h55555555, 4'hF,    1, 1'b1, 32'h0};
        vecs[12] = '{1'b0, 1'b1, 32'd1026,   32'h0,        4'h0,    5, 1'b0, 32'hDEADBEEF};

        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_state", 32'(st0), 32'(IDLE));
        check("rst_ready", 32'(ob[0].ready), 32'd1);
        check("rst_err", 32'(ob[0].err), 32'd0);
        check("rst_read_data", ob[0].rdata, 32'h0);
        check("rst_addr", 32'(ob[0].addr), 32'd0);
        check("rst_strobes_n", 32'({ob[0].we_n, ob[0].ce_n, ob[0].oe_n, ob[0].ub_n, ob[0].lb_n}), 32'h1F);
        check("rst_state_ws", 32'(st1), 32'(IDLE));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) run_txn(0, vecs[i]);

        // Three wait states: four cycles per beat, ready at cycle 9.
        w = '{1'b1, 1'b0, 32'd1024, 32'h0BADF00D, 4'hF, 9, 1'b0, 32'h0};
        run_txn(1, w);
        w = '{1'b0, 1'b1, 32'd1024, 32'h0, 4'h0, 9, 1'b0, 32'h0BADF00D};
        run_txn(1, w);

        // Reset during the first cycle of beat 1 of a write.
        drive(0, 1'b1, 1'b0, 32'd1048, 32'h5555AAAA, 4'hF);
        repeat (3) @(negedge clk);
        #1;
        check("pre_rst_addr", 32'(ob[0].addr), 32'd13);
        check("pre_rst_we_n", 32'(ob[0].we_n), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("abort_state", 32'(st0), 32'(IDLE));
        check("abort_strobes_n", 32'({ob[0].we_n, ob[0].ce_n, ob[0].oe_n}), 32'h7);
        check("abort_read_data", ob[0].rdata, 32'h0);
        check("abort_ready_req", 32'(ob[0].ready), 32'd0);
        drive(0, 1'b0, 1'b0, 32'd1048, 32'h5555AAAA, 4'hF);
        #1;
        check("abort_ready_noreq", 32'(ob[0].ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sram_multibeat_ctrl.md
# sram_multibeat_ctrl

Parametrised successor to the fixed 32-bit/16-bit SRAM controller: bridges a single-word memory-stage request (rd_en/wr_en, address, writeData) onto an asynchronous SRAM with a narrower data bus, splitting each word into DATA_W/SRAM_DQ_W sequential beats. Adds configurable wait states, per-byte write enables, out-of-range detection and a registered read result. It sits between the MEM pipeline stage, which freezes while ready is low, and the board SRAM pins.

## Interface
- DATA_W, 32: requester word width; integer multiple of SRAM_DQ_W (1, 2 or 4 beats).
- SRAM_DQ_W, 16: SRAM data bus width; 16 only in this generation.
- SRAM_ADDR_W, 18: SRAM half-word address width.
- BASE_ADDR, 32'd1024: byte address mapped to SRAM location 0.
- WAIT_CYCLES, 1: extra cycles per beat; must be ≥1.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- wr_en  in  1  write request level.
- rd_en  in  1  read request level.
- address  in  32  byte address.
- writeData  in  DATA_W  write word.
- byteEn  in  DATA_W/8  write byte enables, bit i covers writeData[8i+7:8i].
- readData  out  DATA_W  registered read word.
- ready  out  1  high when no request is pending or the current one completes.
- err  out  1  high with ready when the completed request was out of range.
- SRAM_DQ  inout  SRAM_DQ_W  SRAM data.
- SRAM_ADDR  out  SRAM_ADDR_W  SRAM address.
- SRAM_UB_N, SRAM_LB_N  out  1 each  byte lane strobes, active-low.
- SRAM_WE_N, SRAM_CE_N, SRAM_OE_N  out  1 each  write/chip/output enables, active-low.

## Operation
- BEATS = DATA_W/SRAM_DQ_W; T_BEAT = WAIT_CYCLES+1.
- States: IDLE, ACCESS, DONE. IDLE→ACCESS when (rd_en|wr_en); IDLE→DONE directly if out of range; ACCESS→DONE after last cycle of last beat; DONE→IDLE unconditionally.
- On leaving IDLE, latch op (wr_en has priority when both high), address, writeData, byteEn; input changes during ACCESS/DONE ignored.
- offset = address − BASE_ADDR, aligned down to DATA_W/8 bytes. Out of range if address < BASE_ADDR or offset ≥ 2^SRAM_ADDR_W·2; no SRAM pins toggle, readData set to 0, err=1 in DONE.
- Beat k (0 = least significant slice): SRAM_ADDR = (offset>>1) + k, truncated to SRAM_ADDR_W; CE_N low throughout ACCESS, high otherwise.
- Write beat: DQ driven with writeData slice k for all T_BEAT cycles; WE_N low for first WAIT_CYCLES cycles, high in last (hold); LB_N/UB_N = ~byteEn[2k]/~byteEn[2k+1]; OE_N high.
- Read beat: OE_N low, LB_N/UB_N low, WE_N high, DQ released; slice k of readData captured from SRAM_DQ on the edge ending the beat's last cycle.
- ready = (state==DONE) | (state==IDLE & !rd_en & !wr_en). err low outside DONE.
- A request still asserted when returning to IDLE starts a new transaction.

## Timing
- Reset: state IDLE, readData 0, err 0, SRAM_ADDR 0, WE_N/CE_N/OE_N/UB_N/LB_N all 1, DQ released; reset mid-ACCESS aborts on that edge, no partial-beat completion guaranteed.
- Request first high in cycle 0 (IDLE): ACCESS cycles 1..BEATS·T_BEAT, DONE (ready=1) cycle BEATS·T_BEAT+1. Defaults: ready low cycles 0–4, high cycle 5.
- Out of range: ready low cycle 0, high (err=1) cycle 1.
- readData stable from DONE until the next read's capture; writes leave it unchanged.
- DQ never driven while OE_N low.

## Structure
- Package sram_ctrl_pkg: state enum, BEATS/T_BEAT derivation, clog2 helper, SRAM_DQ_W constant.
- Sub-module sram_beat_counter: beat index and wait-cycle counter with clear, enable, last_cycle and last_beat outputs.

## Test plan
- Default params, write 0xDEADBEEF to 1024, byteEn 4'hF → beats at SRAM_ADDR 0 (0xBEEF) and 1 (0xDEAD), ready high only at cycle 5.
- Read back 1024 → readData 0xDEADBEEF in DONE, err 0, DQ never driven.
- Write 0x11223344 to 1032 with byteEn 4'b0101 → beat 0 LB_N=0/UB_N=1, beat 1 LB_N=0/UB_N=1; readback of model shows only bytes 0x44 and 0x22 updated.
- address 1000 and address 1024+2^19 → ready at cycle 1, err 1, CE_N stays high, readData 0.
- rd_en and wr_en both high → write performed; WAIT_CYCLES=3 → each beat 4 cycles, ready at cycle 9.
- rst asserted during beat 1 of a write → next cycle IDLE, WE_N/CE_N high, DQ released, ready reflects request level.
